// File: rtl/ls245_bus_pkg.sv
// Shared types and constants for the LS245 bus transceiver sequencer.
package ls245_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TURN    = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic DIR_A2B = 1'b1;
  localparam logic DIR_B2A = 1'b0;

  // Width able to hold the larger of the two dwell reload values.
  function automatic int unsigned cnt_width(input int unsigned turn_cyc,
                                            input int unsigned hold_cyc);
    int unsigned m;
    m = (turn_cyc > hold_cyc) ? turn_cyc : hold_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ls245_bus_ctrl.sv
// Break-before-make _DIR/_OE sequencer for an octal bus transceiver pair.
// Define LS245_BUS_CTRL_ERR_EN to enable the sticky request-collision flag on _ERR.
module ls245_bus_ctrl
  import ls245_bus_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic             _CLK,
  input  logic             _RST,
  input  logic             _WR_REQ,
  input  logic             _RD_REQ,
  input  logic [WIDTH-1:0] _ADATA,
  output logic [WIDTH-1:0] _RDATA,
  output logic             _DIR,
  output logic             _OE,
  output logic             _BUSY,
  output logic             _DONE,
  output logic             _ERR
);

  localparam int unsigned      CNT_W     = cnt_width(TURN_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             req_c;
  logic             tgt_c;

  // Next state; outputs decode the next state so they are all registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rdata_d = rdata_q;
    req_c   = _WR_REQ | _RD_REQ;
    tgt_c   = _WR_REQ ? DIR_A2B : DIR_B2A;

    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          if (tgt_c != dir_q) begin
            dir_d   = tgt_c;
            state_d = TURN;
            cnt_d   = TURN_LOAD;
          end else begin
            state_d = ACTIVE;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = ACTIVE;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
          if (dir_q == DIR_B2A) rdata_d = _ADATA;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    oe_d   = (state_d != ACTIVE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == RELEASE);
  end

  always_ff @(posedge _CLK) begin
    if (_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_B2A;
      oe_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef LS245_BUS_CTRL_ERR_EN
  logic err_q, err_d;

  // Sticky until reset; write still wins the arbitration.
  always_comb begin
    err_d = err_q | ((state_q == IDLE) & _WR_REQ & _RD_REQ);
  end

  always_ff @(posedge _CLK) begin
    if (_RST) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign _ERR = err_q;
`else
  assign _ERR = 1'b0;
`endif

  // Direction must hold while enabled and on the edge that enables.
  always @(posedge _CLK) begin
    if (!_RST && (!oe_q || !oe_d)) assert (dir_d == dir_q);
  end

  assign _RDATA = rdata_q;
  assign _DIR   = dir_q;
  assign _OE    = oe_q;
  assign _BUSY  = busy_q;
  assign _DONE  = done_q;

endmodule

// File: tb/tb_ls245_bus_ctrl.sv
// Directed bench for ls245_bus_ctrl: default instance plus a TURN_CYC=3/HOLD_CYC=4 instance.
module tb_ls245_bus_ctrl;

`ifdef LS245_BUS_CTRL_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, wr, rd, wr6, rd6;
  logic [7:0] adata;
  logic [7:0] rdata, rdata6;
  logic       dir, oe, busy, done, err;
  logic       dir6, oe6, busy6, done6, err6;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  ls245_bus_ctrl u_dut (
    ._CLK(clk), ._RST(rst), ._WR_REQ(wr), ._RD_REQ(rd), ._ADATA(adata),
    ._RDATA(rdata), ._DIR(dir), ._OE(oe), ._BUSY(busy), ._DONE(done), ._ERR(err)
  );

  ls245_bus_ctrl #(.WIDTH(8), .TURN_CYC(3), .HOLD_CYC(4)) u_dut6 (
    ._CLK(clk), ._RST(rst), ._WR_REQ(wr6), ._RD_REQ(rd6), ._ADATA(adata),
    ._RDATA(rdata6), ._DIR(dir6), ._OE(oe6), ._BUSY(busy6), ._DONE(done6), ._ERR(err6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0; wr6 = 1'b0; rd6 = 1'b0; adata = 8'h00;
    tick(); tick();
    total++; if (oe !== 1'b1) begin bad++; $display("FAIL rst_oe got=%b exp=1", oe); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL rst_dir got=%b exp=0", dir); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    rst = 1'b0; wr = 1'b1;
    tick();
    tick();
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL mid_active_oe got=%b exp=0", oe); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL mid_active_dir got=%b exp=1", dir); end
    rst = 1'b1; wr = 1'b0;
    tick();
    total++; if (oe !== 1'b1) begin bad++; $display("FAIL midrst_oe got=%b exp=1", oe); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL midrst_dir got=%b exp=0", dir); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL midrst_rdata got=%h exp=00", rdata); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_dropped got=%b exp=0", busy); end
  endtask

  task automatic test_read_same_dir();
    logic e_oe, e_done, e_busy;
    adata = 8'h11; rd = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      e_oe = !(c <= 2); e_done = (c == 3); e_busy = (c <= 3);
      total++; if (oe !== e_oe) begin bad++; $display("FAIL rd_oe c%0d got=%b exp=%b", c, oe, e_oe); end
      total++; if (done !== e_done) begin bad++; $display("FAIL rd_done c%0d got=%b exp=%b", c, done, e_done); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rd_busy c%0d got=%b exp=%b", c, busy, e_busy); end
      total++; if (dir !== 1'b0) begin bad++; $display("FAIL rd_dir c%0d got=%b exp=0", c, dir); end
      if (c == 2) adata = 8'hA5;
      if (c >= 3) begin
        total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL rd_rdata c%0d got=%h exp=a5", c, rdata); end
      end
      if (c == 3) begin rd = 1'b0; adata = 8'h5A; end
      tick();
    end
  endtask

  task automatic test_write_dir_change();
    logic e_oe, e_done, e_busy;
    wr = 1'b1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      e_oe = !(c == 2 || c == 3); e_done = (c == 4); e_busy = (c <= 4);
      total++; if (dir !== 1'b1) begin bad++; $display("FAIL wr_dir c%0d got=%b exp=1", c, dir); end
      total++; if (oe !== e_oe) begin bad++; $display("FAIL wr_oe c%0d got=%b exp=%b", c, oe, e_oe); end
      total++; if (done !== e_done) begin bad++; $display("FAIL wr_done c%0d got=%b exp=%b", c, done, e_done); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL wr_busy c%0d got=%b exp=%b", c, busy, e_busy); end
      if (c == 4) wr = 1'b0;
      tick();
    end
    total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL wr_rdata_hold got=%h exp=a5", rdata); end
  endtask

  task automatic test_back_to_back();
    logic exp_oe [1:9];
    logic exp_dir [1:9];
    logic exp_done [1:9];
    logic prev_oe, prev_dir;
    int   dones;
    exp_oe   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_dir  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dones = 0; prev_oe = 1'b1; prev_dir = 1'b1;
    wr = 1'b1; rd = 1'b0;
    tick();
    for (int c = 1; c <= 9; c++) begin
      total++; if (oe !== exp_oe[c]) begin bad++; $display("FAIL b2b_oe c%0d got=%b exp=%b", c, oe, exp_oe[c]); end
      total++; if (dir !== exp_dir[c]) begin bad++; $display("FAIL b2b_dir c%0d got=%b exp=%b", c, dir, exp_dir[c]); end
      total++; if (done !== exp_done[c]) begin bad++; $display("FAIL b2b_done c%0d got=%b exp=%b", c, done, exp_done[c]); end
      total++;
      if (dir !== prev_dir && !(oe === 1'b1 && prev_oe === 1'b1)) begin
        bad++; $display("FAIL b2b_dir_flip_oe c%0d got oe=%b prev_oe=%b exp both=1", c, oe, prev_oe);
      end
      if (done === 1'b1) dones++;
      if (c == 3) begin wr = 1'b0; rd = 1'b1; adata = 8'hC3; end
      if (c == 8) begin
        total++; if (rdata !== 8'hC3) begin bad++; $display("FAIL b2b_rdata got=%h exp=c3", rdata); end
        rd = 1'b0;
      end
      prev_oe = oe; prev_dir = dir;
      tick();
    end
    total++; if (dones != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
  endtask

  task automatic test_collision();
    logic e_oe, e_done;
    wr = 1'b1; rd = 1'b1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      e_oe = !(c == 2 || c == 3); e_done = (c == 4);
      total++; if (dir !== 1'b1) begin bad++; $display("FAIL col_dir c%0d got=%b exp=1", c, dir); end
      total++; if (oe !== e_oe) begin bad++; $display("FAIL col_oe c%0d got=%b exp=%b", c, oe, e_oe); end
      total++; if (done !== e_done) begin bad++; $display("FAIL col_done c%0d got=%b exp=%b", c, done, e_done); end
      total++; if (err !== EXP_ERR) begin bad++; $display("FAIL col_err c%0d got=%b exp=%b", c, err, EXP_ERR); end
      if (c == 4) begin wr = 1'b0; rd = 1'b0; end
      tick();
    end
    total++; if (rdata !== 8'hC3) begin bad++; $display("FAIL col_rdata got=%h exp=c3", rdata); end
  endtask

  task automatic test_long_hold_drop();
    logic e_oe, e_done, e_busy;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (oe6 !== 1'b1) begin bad++; $display("FAIL long_rst_oe got=%b exp=1", oe6); end
    total++; if (dir6 !== 1'b0) begin bad++; $display("FAIL long_rst_dir got=%b exp=0", dir6); end
    wr6 = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      e_oe = !(c >= 4 && c <= 7); e_done = (c == 8); e_busy = (c <= 8);
      total++; if (oe6 !== e_oe) begin bad++; $display("FAIL long_oe c%0d got=%b exp=%b", c, oe6, e_oe); end
      total++; if (done6 !== e_done) begin bad++; $display("FAIL long_done c%0d got=%b exp=%b", c, done6, e_done); end
      total++; if (busy6 !== e_busy) begin bad++; $display("FAIL long_busy c%0d got=%b exp=%b", c, busy6, e_busy); end
      total++; if (dir6 !== 1'b1) begin bad++; $display("FAIL long_dir c%0d got=%b exp=1", c, dir6); end
      if (c == 5) wr6 = 1'b0;
      tick();
    end
    total++; if (rdata6 !== 8'h00) begin bad++; $display("FAIL long_rdata got=%h exp=00", rdata6); end
    total++; if (err6 !== 1'b0) begin bad++; $display("FAIL long_err got=%b exp=0", err6); end
  endtask

  initial begin
    test_reset();
    test_read_same_dir();
    test_write_dir_change();
    test_back_to_back();
    test_collision();
    test_long_hold_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
